id_ex_hazard_stage: RTL and testbench

Pipeline stage directly downstream of the opcode decoder. It registers the decoded 20-bit control bundle and operands into the ID/EX boundary. It detects load-use hazards against the instruction already in EX and inserts bubbles. It squashes wrong-path instructions after a taken `bne`. It also keeps a saturating stall counter for performance debug.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_hazard_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle bit map, opcodes and hazard FSM states.
package cpu_pkg;

  localparam int unsigned CTRL_W   = 20;
  localparam int unsigned OPCODE_W = 5;

  // Control bundle bit indices
  localparam int unsigned CTRL_RSVD       = 19;
  localparam int unsigned CTRL_LOAD       = 18;
  localparam int unsigned CTRL_WRE        = 17;
  localparam int unsigned CTRL_VWRE       = 16;
  localparam int unsigned CTRL_WMEM_A     = 15;
  localparam int unsigned CTRL_WMEM_B     = 14;
  localparam int unsigned CTRL_WB_HI      = 13;
  localparam int unsigned CTRL_WB_LO      = 12;
  localparam int unsigned CTRL_VWB_HI     = 11;
  localparam int unsigned CTRL_VWB_LO     = 10;
  localparam int unsigned CTRL_ALUOP_HI   = 9;
  localparam int unsigned CTRL_ALUOP_LO   = 5;
  localparam int unsigned CTRL_VALUOP_HI  = 4;
  localparam int unsigned CTRL_VALUOP_LO  = 0;

  // Opcode bit that selects the vector register file
  localparam int unsigned OP_CLASS_BIT = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDR  = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_VLDR = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 5'b00011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  // True when the opcode addresses the vector register file
  function automatic logic is_vector(input logic [OPCODE_W-1:0] op);
    return op[OP_CLASS_BIT];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the EX and ID slots.
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int unsigned REG_W = 4
) (
  input  logic                ex_valid,
  input  logic                ex_load,
  input  logic [OPCODE_W-1:0] ex_opcode,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  output logic                hazard
);

  logic same_class;
  logic rd_match;

  // Hazard only when a load in EX writes a register the ID instruction reads in the same file
  always_comb begin
    same_class = (is_vector(ex_opcode) == is_vector(id_opcode));
    rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    hazard     = ex_valid && ex_load && id_valid && (id_opcode != OP_NOP) &&
                 same_class && rd_match;
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stalling, branch squash and a bubble counter.
module id_ex_hazard_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned VDATA_W      = 128,
  parameter int unsigned REG_W        = 4,
  parameter int unsigned BRANCH_FLUSH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [CTRL_W-1:0]   id_control_signals,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [DATA_W-1:0]   id_src_a,
  input  logic [DATA_W-1:0]   id_src_b,
  input  logic [VDATA_W-1:0]  id_vsrc_a,
  input  logic [VDATA_W-1:0]  id_vsrc_b,
  input  logic                branch_taken,
  input  logic                ex_hold,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [CTRL_W-1:0]   ex_control_signals,
  output logic [OPCODE_W-1:0] ex_opcode,
  output logic [REG_W-1:0]    ex_rd,
  output logic [DATA_W-1:0]   ex_src_a,
  output logic [DATA_W-1:0]   ex_src_b,
  output logic [VDATA_W-1:0]  ex_vsrc_a,
  output logic [VDATA_W-1:0]  ex_vsrc_b,
  output logic [15:0]         stall_count
);

  localparam int unsigned FcntW = (BRANCH_FLUSH > 1) ? $clog2(BRANCH_FLUSH) : 1;
  // Remaining squash slots after the cycle branch_taken itself is seen
  localparam logic [FcntW-1:0] FlushInit = FcntW'(BRANCH_FLUSH - 1);

  hz_state_t          state_q, state_d;
  logic [FcntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic               ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d;
  logic [OPCODE_W-1:0] ex_opcode_q, ex_opcode_d;
  logic [REG_W-1:0]   ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0]  ex_src_a_q, ex_src_a_d;
  logic [DATA_W-1:0]  ex_src_b_q, ex_src_b_d;
  logic [VDATA_W-1:0] ex_vsrc_a_q, ex_vsrc_a_d;
  logic [VDATA_W-1:0] ex_vsrc_b_q, ex_vsrc_b_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic bubble;   // stall/squash bubble, counted
  logic latch;    // take the ID slot (may itself be an empty slot)

  load_use_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .ex_valid  (ex_valid_q),
    .ex_load   (ex_ctrl_q[CTRL_LOAD]),
    .ex_opcode (ex_opcode_q),
    .ex_rd     (ex_rd_q),
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .hazard    (hazard)
  );

  // FSM next state and per-cycle action selection, in priority order
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    bubble      = 1'b0;
    latch       = 1'b0;
    if (branch_taken) begin
      bubble      = 1'b1;
      flush_cnt_d = FlushInit;
      state_d     = (FlushInit != '0) ? FLUSH : RUN;
    end else if (!ex_hold) begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            bubble  = 1'b1;
            state_d = LU_STALL;
          end else begin
            latch = 1'b1;
          end
        end
        LU_STALL: begin
          latch   = 1'b1;
          state_d = RUN;
        end
        FLUSH: begin
          bubble      = 1'b1;
          flush_cnt_d = flush_cnt_q - FcntW'(1);
          if (flush_cnt_d == '0) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

  // EX register next values: hold, bubble, or copy of the ID slot
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_opcode_d = ex_opcode_q;
    ex_rd_d     = ex_rd_q;
    ex_src_a_d  = ex_src_a_q;
    ex_src_b_d  = ex_src_b_q;
    ex_vsrc_a_d = ex_vsrc_a_q;
    ex_vsrc_b_d = ex_vsrc_b_q;
    if (bubble || (latch && !id_valid)) begin
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = '0;
      ex_opcode_d = OP_NOP;
      ex_rd_d     = '0;
      ex_src_a_d  = '0;
      ex_src_b_d  = '0;
      ex_vsrc_a_d = '0;
      ex_vsrc_b_d = '0;
    end else if (latch) begin
      ex_valid_d  = 1'b1;
      ex_ctrl_d   = id_control_signals;
      ex_opcode_d = id_opcode;
      ex_rd_d     = id_rd;
      ex_src_a_d  = id_src_a;
      ex_src_b_d  = id_src_b;
      ex_vsrc_a_d = id_vsrc_a;
      ex_vsrc_b_d = id_vsrc_b;
    end
  end

  // Saturating bubble counter; empty ID slots are not stalls and do not count
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bubble && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // IF/ID holds on back-pressure or while a load-use bubble is inserted
  always_comb begin
    id_stall = !rst && !branch_taken && (ex_hold || ((state_q == RUN) && hazard));
  end

  // State and EX register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_opcode_q <= OP_NOP;
      ex_rd_q     <= '0;
      ex_src_a_q  <= '0;
      ex_src_b_q  <= '0;
      ex_vsrc_a_q <= '0;
      ex_vsrc_b_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_opcode_q <= ex_opcode_d;
      ex_rd_q     <= ex_rd_d;
      ex_src_a_q  <= ex_src_a_d;
      ex_src_b_q  <= ex_src_b_d;
      ex_vsrc_a_q <= ex_vsrc_a_d;
      ex_vsrc_b_q <= ex_vsrc_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid           = ex_valid_q;
  assign ex_control_signals = ex_ctrl_q;
  assign ex_opcode          = ex_opcode_q;
  assign ex_rd              = ex_rd_q;
  assign ex_src_a           = ex_src_a_q;
  assign ex_src_b           = ex_src_b_q;
  assign ex_vsrc_a          = ex_vsrc_a_q;
  assign ex_vsrc_b          = ex_vsrc_b_q;
  assign stall_count        = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage.
module tb_id_ex_hazard_stage;

  localparam logic [4:0]  OpAdd   = 5'b00101;
  localparam logic [4:0]  OpLdr   = 5'b00010;
  localparam logic [4:0]  OpVldr  = 5'b10010;
  localparam logic [4:0]  OpArk   = 5'b10100;
  localparam logic [19:0] CtlAdd  = 20'h28CA5;
  localparam logic [19:0] CtlLdr  = 20'h62000;
  localparam logic [19:0] CtlVldr = 20'h50800;
  localparam logic [19:0] CtlArk  = 20'h10401;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_opcode;
  logic [19:0]   id_control_signals;
  logic [3:0]    id_rs1, id_rs2, id_rd;
  logic [15:0]   id_src_a, id_src_b;
  logic [127:0]  id_vsrc_a, id_vsrc_b;
  logic          branch_taken;
  logic          ex_hold;
  logic          id_stall;
  logic          ex_valid;
  logic [19:0]   ex_control_signals;
  logic [4:0]    ex_opcode;
  logic [3:0]    ex_rd;
  logic [15:0]   ex_src_a, ex_src_b;
  logic [127:0]  ex_vsrc_a, ex_vsrc_b;
  logic [15:0]   stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_hazard_stage #(
    .DATA_W       (16),
    .VDATA_W      (128),
    .REG_W        (4),
    .BRANCH_FLUSH (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .id_valid           (id_valid),
    .id_opcode          (id_opcode),
    .id_control_signals (id_control_signals),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_rd              (id_rd),
    .id_src_a           (id_src_a),
    .id_src_b           (id_src_b),
    .id_vsrc_a          (id_vsrc_a),
    .id_vsrc_b          (id_vsrc_b),
    .branch_taken       (branch_taken),
    .ex_hold            (ex_hold),
    .id_stall           (id_stall),
    .ex_valid           (ex_valid),
    .ex_control_signals (ex_control_signals),
    .ex_opcode          (ex_opcode),
    .ex_rd              (ex_rd),
    .ex_src_a           (ex_src_a),
    .ex_src_b           (ex_src_b),
    .ex_vsrc_a          (ex_vsrc_a),
    .ex_vsrc_b          (ex_vsrc_b),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] op, input logic [19:0] ctl,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic [15:0] a);
    id_valid           = v;
    id_opcode          = op;
    id_control_signals = ctl;
    id_rs1             = rs1;
    id_rs2             = rs2;
    id_rd              = rd;
    id_src_a           = a;
    id_src_b           = ~a;
    id_vsrc_a          = {8{a}};
    id_vsrc_b          = {8{~a}};
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, ex_valid, 1'b0);
    check({tag, ".ctrl"}, ex_control_signals, 20'h0);
    check({tag, ".op"}, ex_opcode, 5'h0);
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; ex_hold = 1'b0;
    set_id(1'b1, OpAdd, CtlAdd, 4'd1, 4'd2, 4'd5, 16'hA001);

    // Reset with a real instruction presented
    tick(); tick();
    check("rst.stall", id_stall, 1'b0);
    check_bubble("rst");
    check("rst.src_a", ex_src_a, 16'h0);
    check("rst.cnt", stall_count, 16'h0);
    rst = 1'b0;
    tick();
    check("rel.ctrl", ex_control_signals, CtlAdd);
    check("rel.valid", ex_valid, 1'b1);
    check("rel.op", ex_opcode, OpAdd);
    check("rel.src_a", ex_src_a, 16'hA001);
    check("rel.vsrc_b", ex_vsrc_b, {8{16'h5FFE}});

    // Scalar load-use: ldr r3 then add r3
    set_id(1'b1, OpLdr, CtlLdr, 4'd1, 4'd2, 4'd3, 16'hB002);
    #1 check("lu.nostall", id_stall, 1'b0);
    tick();
    set_id(1'b1, OpAdd, CtlAdd, 4'd3, 4'd4, 4'd5, 16'hC003);
    #1 check("lu.stall", id_stall, 1'b1);
    tick();
    check_bubble("lu.bub");
    check("lu.cnt", stall_count, 16'd1);
    check("lu.stall2", id_stall, 1'b0);
    tick();
    check("lu.ctrl", ex_control_signals, CtlAdd);
    check("lu.rd", ex_rd, 4'd5);
    check("lu.src_a", ex_src_a, 16'hC003);
    check("lu.cnt2", stall_count, 16'd1);

    // Vector load followed by scalar reader: different file, no stall
    set_id(1'b1, OpVldr, CtlVldr, 4'd6, 4'd7, 4'd3, 16'hD004);
    tick();
    set_id(1'b1, OpAdd, CtlAdd, 4'd1, 4'd3, 4'd5, 16'hE005);
    #1 check("cls.nostall", id_stall, 1'b0);
    tick();
    check("cls.ctrl", ex_control_signals, CtlAdd);
    check("cls.cnt", stall_count, 16'd1);
    // Vector load followed by vector reader: stall
    set_id(1'b1, OpVldr, CtlVldr, 4'd6, 4'd7, 4'd3, 16'hD006);
    tick();
    set_id(1'b1, OpArk, CtlArk, 4'd3, 4'd8, 4'd9, 16'hF007);
    #1 check("vec.stall", id_stall, 1'b1);
    tick();
    check_bubble("vec.bub");
    check("vec.cnt", stall_count, 16'd2);
    tick();
    check("vec.ctrl", ex_control_signals, CtlArk);
    check("vec.vsrc_a", ex_vsrc_a, {8{16'hF007}});

    // Taken branch: two bubbles even with a valid ID slot
    set_id(1'b1, OpAdd, CtlAdd, 4'd1, 4'd2, 4'd5, 16'h1111);
    branch_taken = 1'b1;
    #1 check("br.stall", id_stall, 1'b0);
    tick();
    branch_taken = 1'b0;
    check_bubble("br.b1");
    check("br.cnt1", stall_count, 16'd3);
    tick();
    check_bubble("br.b2");
    check("br.cnt2", stall_count, 16'd4);
    tick();
    check("br.resume", ex_control_signals, CtlAdd);
    check("br.cnt3", stall_count, 16'd4);

    // Branch while in LU_STALL: the held instruction must not be latched
    set_id(1'b1, OpLdr, CtlLdr, 4'd1, 4'd2, 4'd3, 16'h2222);
    tick();
    set_id(1'b1, OpAdd, CtlAdd, 4'd3, 4'd4, 4'd5, 16'h3333);
    tick();
    check("bls.cnt1", stall_count, 16'd5);
    branch_taken = 1'b1;
    #1 check("bls.stall", id_stall, 1'b0);
    tick();
    branch_taken = 1'b0;
    check_bubble("bls.b1");
    tick();
    check_bubble("bls.b2");
    check("bls.cnt2", stall_count, 16'd7);
    tick();
    check("bls.resume", ex_control_signals, CtlAdd);

    // Back-pressure with a load in EX
    set_id(1'b1, OpLdr, CtlLdr, 4'd1, 4'd2, 4'd3, 16'h4444);
    tick();
    set_id(1'b1, OpAdd, CtlAdd, 4'd3, 4'd4, 4'd5, 16'h5555);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold.stall", id_stall, 1'b1);
      tick();
      check("hold.ctrl", ex_control_signals, CtlLdr);
      check("hold.src_a", ex_src_a, 16'h4444);
      check("hold.cnt", stall_count, 16'd7);
    end
    ex_hold = 1'b0;
    #1 check("hold.lu", id_stall, 1'b1);
    tick();
    check_bubble("hold.bub");
    check("hold.cnt2", stall_count, 16'd8);
    tick();
    check("hold.resume", ex_src_a, 16'h5555);

    // Reset mid-flush: back to RUN, no replayed bubble
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    check("rflush.cnt", stall_count, 16'd0);
    rst = 1'b0;
    set_id(1'b1, OpAdd, CtlAdd, 4'd1, 4'd2, 4'd5, 16'h6666);
    tick();
    check("rflush.valid", ex_valid, 1'b1);
    // Empty ID slot latches as a bubble but is not a stall
    set_id(1'b0, OpAdd, CtlAdd, 4'd1, 4'd2, 4'd5, 16'h7777);
    tick();
    check_bubble("empty");
    check("empty.cnt", stall_count, 16'd0);

    // Saturation: continuous branch squash
    branch_taken = 1'b1;
    repeat (65534) tick();
    check("sat.pre", stall_count, 16'hFFFE);
    repeat (3) tick();
    check("sat.cnt", stall_count, 16'hFFFF);
    branch_taken = 1'b0;
    set_id(1'b1, OpAdd, CtlAdd, 4'd1, 4'd2, 4'd5, 16'h8888);
    tick();
    tick();
    check("sat.resume", ex_src_a, 16'h8888);
    check("sat.hold", stall_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
